// File: rtl/ipe_channel_dispatch.sv
// Store-and-forward packet dispatcher: buffers ingress packets with their status,
// picks a destination channel (round robin or port bind) and streams packets out whole.
//
// state    | meaning
// IDLE     | wait for a queued status entry and no downstream backpressure; pop it
// SELECT   | pick channel; on grant emit the rewritten head word, else start discard
// SEND     | stream remaining words one per cycle through the tail
// DISCARD  | pop words silently through the tail
module ipe_channel_dispatch #(
    parameter int CH_W      = 6,
    parameter int PKT_DEPTH = 256,
    parameter int VLD_DEPTH = 32,
    parameter int AF_MARGIN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_W-1:0]      in_fpgaac_channel_num,
    input  logic                 in_fpgaac_cpuid_cs,
    input  logic [2**CH_W-1:0]   cpuid_valid,
    input  logic                 in_ingress_pkt_wr,
    input  logic [133:0]         in_ingress_pkt,
    input  logic                 in_ingress_valid_wr,
    input  logic                 in_ingress_valid,
    output logic                 out_ingress_pkt_almostfull,
    output logic                 out_rdma_pkt_wr,
    output logic [133:0]         out_rdma_pkt,
    output logic                 out_rdma_valid_wr,
    output logic                 out_rdma_valid,
    input  logic                 in_rdma_pkt_almostfull,
    output logic [31:0]          out_drop_cnt
);

    localparam int NCH  = 2**CH_W;
    localparam int PA_W = $clog2(PKT_DEPTH);
    localparam int VA_W = $clog2(VLD_DEPTH);

    typedef enum logic [1:0] {IDLE, SELECT, SEND, DISCARD} state_t;

    state_t state, state_nxt;

    // data FIFO
    logic [133:0]  pkt_mem [PKT_DEPTH];
    logic [PA_W-1:0] pkt_wp, pkt_rp;
    logic [PA_W:0]   pkt_cnt;
    logic            pkt_push, pkt_pop, pkt_empty;
    logic [133:0]    pkt_head;

    // status FIFO
    logic [VLD_DEPTH-1:0] vld_mem;
    logic [VA_W-1:0] vld_wp, vld_rp;
    logic [VA_W:0]   vld_cnt;
    logic            vld_push, vld_pop, vld_empty;
    logic            stat_q;

    logic [CH_W-1:0] rr_ptr, ptr_eff, hi_id, lo_id, port_id, grant_id;
    logic [NCH-1:0]  elig;
    logic            hi_found, lo_found, port_ok;
    logic            emit, ptr_upd, drop_inc, is_tail;
    logic [133:0]    head_mod;

    assign pkt_push  = in_ingress_pkt_wr && (pkt_cnt != (PA_W+1)'(PKT_DEPTH));
    assign vld_push  = in_ingress_valid_wr && (vld_cnt != (VA_W+1)'(VLD_DEPTH));
    assign pkt_empty = (pkt_cnt == '0);
    assign vld_empty = (vld_cnt == '0);
    assign pkt_head  = pkt_mem[pkt_rp];
    assign is_tail   = (pkt_head[133:132] == 2'b10);

    always_ff @(posedge clk) begin
        if (pkt_push) pkt_mem[pkt_wp] <= in_ingress_pkt;
        if (vld_push) vld_mem[vld_wp] <= in_ingress_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_wp  <= '0;
            pkt_rp  <= '0;
            pkt_cnt <= '0;
            vld_wp  <= '0;
            vld_rp  <= '0;
            vld_cnt <= '0;
        end else begin
            if (pkt_push) pkt_wp <= pkt_wp + PA_W'(1);
            if (pkt_pop)  pkt_rp <= pkt_rp + PA_W'(1);
            if (pkt_push && !pkt_pop)      pkt_cnt <= pkt_cnt + (PA_W+1)'(1);
            else if (!pkt_push && pkt_pop) pkt_cnt <= pkt_cnt - (PA_W+1)'(1);
            if (vld_push) vld_wp <= vld_wp + VA_W'(1);
            if (vld_pop)  vld_rp <= vld_rp + VA_W'(1);
            if (vld_push && !vld_pop)      vld_cnt <= vld_cnt + (VA_W+1)'(1);
            else if (!vld_push && vld_pop) vld_cnt <= vld_cnt - (VA_W+1)'(1);
        end
    end

    // Channel choice. Ineligible ids above N are zero in elig, so "first set bit
    // above the pointer, else lowest set bit" is the wrapping round-robin search.
    always_comb begin
        elig     = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < NCH; i++)
            elig[i] = cpuid_valid[i] && (i < int'(in_fpgaac_channel_num));
        ptr_eff = (rr_ptr >= in_fpgaac_channel_num) ? in_fpgaac_channel_num - CH_W'(1) : rr_ptr;
        for (int i = NCH-1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_id    = CH_W'(i);
                if (i > int'(ptr_eff)) begin
                    hi_found = 1'b1;
                    hi_id    = CH_W'(i);
                end
            end
        end
        port_id  = CH_W'(pkt_head[111:106]);
        port_ok  = elig[port_id];
        if (in_fpgaac_cpuid_cs && port_ok) grant_id = port_id;
        else if (hi_found)                 grant_id = hi_id;
        else                               grant_id = lo_id;
        head_mod = pkt_head;
        head_mod[117:112] = 6'(grant_id);
    end

    always_comb begin
        state_nxt = state;
        vld_pop   = 1'b0;
        pkt_pop   = 1'b0;
        emit      = 1'b0;
        ptr_upd   = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!vld_empty && !in_rdma_pkt_almostfull) begin
                    vld_pop   = 1'b1;
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (!stat_q || !lo_found) begin
                    drop_inc  = stat_q;
                    state_nxt = DISCARD;
                end else begin
                    pkt_pop   = 1'b1;
                    emit      = 1'b1;
                    ptr_upd   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!pkt_empty) begin
                    pkt_pop = 1'b1;
                    emit    = 1'b1;
                    if (is_tail) state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (!pkt_empty) begin
                    pkt_pop = 1'b1;
                    if (is_tail) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            stat_q                     <= 1'b0;
            rr_ptr                     <= '1;
            out_drop_cnt               <= '0;
            out_rdma_pkt_wr            <= 1'b0;
            out_rdma_pkt               <= '0;
            out_rdma_valid_wr          <= 1'b0;
            out_rdma_valid             <= 1'b0;
            out_ingress_pkt_almostfull <= 1'b0;
        end else begin
            state <= state_nxt;
            if (vld_pop)  stat_q <= vld_mem[vld_rp];
            if (ptr_upd)  rr_ptr <= grant_id;
            if (drop_inc && out_drop_cnt != 32'hFFFF_FFFF)
                out_drop_cnt <= out_drop_cnt + 32'd1;
            out_rdma_pkt_wr   <= emit;
            out_rdma_pkt      <= !emit ? '0 : (state == SELECT) ? head_mod : pkt_head;
            out_rdma_valid_wr <= emit && is_tail;
            out_rdma_valid    <= emit && is_tail;
            out_ingress_pkt_almostfull <=
                ((PKT_DEPTH - int'(pkt_cnt)) < AF_MARGIN) || ((VLD_DEPTH - int'(vld_cnt)) < 2);
        end
    end

endmodule
